// File: rtl/cipher_rx_decrypt.sv
// Serial XOR-cipher receiver: loads a short key bit-serially, captures a MSG_SIZE-bit
// ciphertext frame MSB-first, and presents the decrypted plaintext with a one-cycle valid pulse.
module cipher_rx_decrypt #(
  parameter int MSG_SIZE = 64,
  parameter int KEY_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                iLoad_key,
  input  logic                iKey_bit,
  input  logic                iSerial_in,
  input  logic                iSerial_flag,
  output logic [MSG_SIZE-1:0] oPlaintext,
  output logic                oValid,
  output logic                oKey_ready,
  output logic                oBusy,
  output logic                oFrame_error
);

  localparam int BW = $clog2(MSG_SIZE) + 1;
  localparam int KW = $clog2(KEY_SIZE) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(MSG_SIZE - 1);
  localparam logic [KW-1:0] KEY_FULL = KW'(KEY_SIZE);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RECV    = 3'd1;
  localparam logic [2:0] DECRYPT = 3'd2;
  localparam logic [2:0] DONE    = 3'd3;
  localparam logic [2:0] ERR     = 3'd4;

  logic [2:0]          state, state_nxt;
  logic [BW-1:0]       bit_cnt;
  logic [KW-1:0]       key_cnt, key_cnt_nxt;
  logic [MSG_SIZE-1:0] cipher;
  logic [MSG_SIZE-1:0] key_pad;
  logic [KEY_SIZE-1:0] key;
  logic                key_ready;
  logic                load_d;
  logic                flag_d;
  logic                frame_start;

  assign key_pad     = {(MSG_SIZE / KEY_SIZE){key}};
  // A frame only starts on a low-to-high flag, so a flag held high after DONE cannot retrigger.
  assign frame_start = iSerial_flag && !flag_d && key_ready;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = RECV;
      RECV: begin
        if (!iSerial_flag)           state_nxt = ERR;
        else if (bit_cnt == LAST_BIT) state_nxt = DECRYPT;
      end
      DECRYPT: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A rising load window restarts the count at the first sampled bit; otherwise saturate.
  always_comb begin
    key_cnt_nxt = KW'(1);
    if (load_d) key_cnt_nxt = (key_cnt == KEY_FULL) ? key_cnt : key_cnt + KW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; reset clears every register,
  // including the data shift registers, so no partial frame or key survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      key_cnt    <= '0;
      cipher     <= '0;
      key        <= '0;
      key_ready  <= 1'b0;
      load_d     <= 1'b0;
      flag_d     <= 1'b0;
      oPlaintext <= '0;
    end else if (ena) begin
      state  <= state_nxt;
      load_d <= iLoad_key;
      flag_d <= iSerial_flag;

      if (state == IDLE && iLoad_key) begin
        key       <= {key[KEY_SIZE-2:0], iKey_bit};
        key_cnt   <= key_cnt_nxt;
        key_ready <= (key_cnt_nxt == KEY_FULL);
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            cipher  <= {{(MSG_SIZE-1){1'b0}}, iSerial_in};
            bit_cnt <= BW'(1);
          end
        end
        RECV: begin
          if (iSerial_flag) begin
            cipher  <= {cipher[MSG_SIZE-2:0], iSerial_in};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DECRYPT: begin
          oPlaintext <= cipher ^ key_pad;
          bit_cnt    <= '0;
        end
        ERR: begin
          cipher  <= '0;
          bit_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign oValid       = (state == DONE);
  assign oFrame_error = (state == ERR);
  assign oBusy        = (state == RECV) || (state == DECRYPT);
  assign oKey_ready   = key_ready;

endmodule

// File: doc/cipher_rx_decrypt.md
CIPHER_RX_DECRYPT -- requirements
Module: cipher_rx_decrypt

Interface
REQ-001 SHALL have parameter MSG_SIZE, default 64, ciphertext/plaintext width in bits.
REQ-002 SHALL have parameter KEY_SIZE, default 8, XOR key width in bits; MSG_SIZE is an integer multiple of KEY_SIZE.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  in  1  enable; low freezes all state.
REQ-006 SHALL have port iLoad_key  in  1  key-load window; key bits sampled while high.
REQ-007 SHALL have port iKey_bit  in  1  serial key bit, MSB first.
REQ-008 SHALL have port iSerial_in  in  1  serial ciphertext bit, MSB first.
REQ-009 SHALL have port iSerial_flag  in  1  ciphertext-valid flag from the transmitting chip.
REQ-010 SHALL have port oPlaintext  out  MSG_SIZE  decrypted message, held until next decrypt.
REQ-011 SHALL have port oValid  out  1  one-cycle pulse when oPlaintext updates.
REQ-012 SHALL have port oKey_ready  out  1  high once KEY_SIZE key bits loaded.
REQ-013 SHALL have port oBusy  out  1  high in RECV or DECRYPT.
REQ-014 SHALL have port oFrame_error  out  1  one-cycle pulse on short frame.

Function
REQ-015 SHALL implement FSM states IDLE, RECV, DECRYPT, DONE, ERR; every transition gated by ena=1.
REQ-016 Key: while iLoad_key=1 in IDLE, SHALL shift iKey_bit into key register MSB-first, one bit per cycle; key bit counter saturates at KEY_SIZE; oKey_ready=1 when counter reaches KEY_SIZE; extra bits keep shifting (last KEY_SIZE bits kept).
REQ-017 Rising iLoad_key (low-to-high) SHALL clear key counter and oKey_ready before the first sample.
REQ-018 iLoad_key outside IDLE SHALL be ignored; key frozen for the whole frame.
REQ-019 IDLE->RECV when iSerial_flag=1, oKey_ready=1 and flag was low the previous cycle; that cycle's iSerial_in is bit MSG_SIZE-1.
REQ-020 iSerial_flag while oKey_ready=0 SHALL be ignored; no error pulse.
REQ-021 RECV: one bit shifted per cycle with iSerial_flag=1; bit counter width clog2(MSG_SIZE)+1.
REQ-022 RECV->DECRYPT on the edge sampling bit MSG_SIZE (64th bit); later bits while flag stays high ignored.
REQ-023 RECV->ERR if iSerial_flag=0 before MSG_SIZE bits; ERR pulses oFrame_error for one cycle, discards partial data, oPlaintext unchanged, then IDLE.
REQ-024 DECRYPT: oPlaintext <= ciphertext XOR {MSG_SIZE/KEY_SIZE copies of key}; key byte aligned to every KEY_SIZE slice; then DONE.
REQ-025 DONE: oValid=1 for exactly one cycle; next state IDLE.
REQ-026 Latency: oValid high in the cycle two edges after the edge sampling the final ciphertext bit.
REQ-027 New frame SHALL require iSerial_flag low for at least one cycle after the previous frame (no back-to-back frames on held flag).
REQ-028 ena=0 mid-frame SHALL hold counters, shift registers and state; reception resumes on ena=1 without error.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, oPlaintext=0, oValid=0, oKey_ready=0, oBusy=0, oFrame_error=0, all counters and key/ciphertext registers 0.
REQ-030 Reset mid-frame or mid-key-load SHALL discard partial data; key must be reloaded after reset.

Verification
REQ-031 Load key 0xA5, send ciphertext 0x0123456789ABCDEF as 64-bit frame -> oPlaintext=0xA486E0C22C0E684A, oValid one pulse 2 cycles after bit 64, oFrame_error=0.
REQ-032 Key 0xA5 loaded, flag dropped after 20 bits -> oFrame_error one pulse, oValid=0, oPlaintext unchanged, state IDLE.
REQ-033 No key loaded, full 64-bit frame sent -> no oValid, no oFrame_error, oBusy stays 0.
REQ-034 Flag held high for 70 bits, key 0xFF -> exactly one oValid, plaintext = first 64 bits XOR 0xFFFFFFFFFFFFFFFF; second frame accepted only after flag low.
REQ-035 ena=0 for 5 cycles at bit 30 of a frame -> identical plaintext to uninterrupted run, oFrame_error=0.
REQ-036 rst_n=0 at bit 40 of a frame -> all outputs 0 immediately; after reset, frame without key reload produces no oValid.
